// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_port_arbiter
//  Purpose  : Round-robin owner of the register file's single rd/wn port.
//             Grants one requester at a time, drives rd/wn/reg_id/write_data
//             and returns registered read data to the requester that asked.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_write/req_reg_id/req_wdata - flattened requests
//             req_ready - one-hot grant pulse, rsp_valid/rsp_data - read reply
//             rf_rd/rf_wn/rf_reg_id/rf_write_data/rf_read_data - regfile side
//             busy - high while a transaction is in ISSUE or CAPTURE
//  Config   : RF_ARB_WRITE_FIRST_EN - when defined, pending writes are
//             arbitrated ahead of pending reads.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int REG_ID_W = 4,
    parameter int DATA_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*REG_ID_W-1:0]  req_reg_id,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rf_rd,
    output logic                         rf_wn,
    output logic [REG_ID_W-1:0]          rf_reg_id,
    output logic [DATA_W-1:0]            rf_write_data,
    input  logic [DATA_W-1:0]            rf_read_data,
    output logic                         busy
);

    localparam int                PTR_W  = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]  c_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]    c_NUM  = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t               r_state,        w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr,       w_rr_ptr_nxt;
    logic [PTR_W-1:0]     r_owner,        w_owner_nxt;
    logic [NUM_REQ-1:0]   r_req_ready,    w_req_ready_nxt;
    logic [NUM_REQ-1:0]   r_rsp_valid,    w_rsp_valid_nxt;
    logic [DATA_W-1:0]    r_rsp_data,     w_rsp_data_nxt;
    logic                 r_rf_rd,        w_rf_rd_nxt;
    logic                 r_rf_wn,        w_rf_wn_nxt;
    logic [REG_ID_W-1:0]  r_rf_reg_id,    w_rf_reg_id_nxt;
    logic [DATA_W-1:0]    r_rf_wdata,     w_rf_wdata_nxt;
    logic                 r_busy;

    // Arbitration helpers
    logic [NUM_REQ-1:0]   w_cand;
    logic [PTR_W:0]       w_sum;
    logic                 w_found;
    logic [PTR_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic                 w_sel_write;
    logic [REG_ID_W-1:0]  w_sel_id;
    logic [DATA_W-1:0]    w_sel_wdata;

    // Candidate set: in write-first builds, reads only compete when no
    // write is pending.
`ifdef RF_ARB_WRITE_FIRST_EN
    logic [NUM_REQ-1:0]   w_wr_pend;
    assign w_wr_pend = req_valid & req_write;
    assign w_cand    = (|w_wr_pend) ? w_wr_pend : req_valid;
`else
    assign w_cand    = req_valid;
`endif

    // First candidate at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && w_cand[w_sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PTR_W-1:0];
            end
        end
    end

    // Winner's request fields and one-hot decodes of winner / owner.
    always_comb begin
        w_win_oh    = '0;
        w_owner_oh  = '0;
        w_sel_write = 1'b0;
        w_sel_id    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == w_winner) begin
                w_win_oh[i] = w_found;
                w_sel_write = req_write[i];
                w_sel_id    = req_reg_id[i*REG_ID_W +: REG_ID_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
            if (PTR_W'(i) == r_owner) begin
                w_owner_oh[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rf_rd_nxt     = 1'b0;
        w_rf_wn_nxt     = 1'b0;
        w_rf_reg_id_nxt = r_rf_reg_id;
        w_rf_wdata_nxt  = r_rf_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_rf_rd_nxt     = ~w_sel_write;
                    w_rf_wn_nxt     = w_sel_write;
                    w_rf_reg_id_nxt = w_sel_id;
                    w_rf_wdata_nxt  = w_sel_wdata;
                    w_req_ready_nxt = w_win_oh;
                    w_owner_nxt     = w_winner;
                    w_rr_ptr_nxt    = (w_winner == c_LAST) ? '0 : w_winner + PTR_W'(1);
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // rf_wn is still high here only for a write; writes need no reply.
                w_state_nxt = r_rf_wn ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                w_rsp_data_nxt  = rf_read_data;
                w_rsp_valid_nxt = w_owner_oh;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rf_rd     <= 1'b0;
            r_rf_wn     <= 1'b0;
            r_rf_reg_id <= '0;
            r_rf_wdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rf_rd     <= w_rf_rd_nxt;
            r_rf_wn     <= w_rf_wn_nxt;
            r_rf_reg_id <= w_rf_reg_id_nxt;
            r_rf_wdata  <= w_rf_wdata_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rf_rd         = r_rf_rd;
    assign rf_wn         = r_rf_wn;
    assign rf_reg_id     = r_rf_reg_id;
    assign rf_write_data = r_rf_wdata;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_port_arbiter
//  Purpose  : Directed and random self-checking bench for regfile_port_arbiter
//             with a behavioural 16x16 register file attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;

    localparam int NUM = 3;

    logic            clk;
    logic            reset;
    logic [NUM-1:0]  req_valid;
    logic [NUM-1:0]  req_write;
    logic [NUM*4-1:0]  req_reg_id;
    logic [NUM*16-1:0] req_wdata;
    logic [NUM-1:0]  req_ready;
    logic [NUM-1:0]  rsp_valid;
    logic [15:0]     rsp_data;
    logic            rf_rd;
    logic            rf_wn;
    logic [3:0]      rf_reg_id;
    logic [15:0]     rf_write_data;
    logic [15:0]     rf_read_data;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_port_arbiter #(.NUM_REQ(NUM), .REG_ID_W(4), .DATA_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_reg_id    (req_reg_id),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rf_rd         (rf_rd),
        .rf_wn         (rf_wn),
        .rf_reg_id     (rf_reg_id),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: write on wn, registered read on rd.
    logic        mdl_init;
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (mdl_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 16'(k) * 16'h1111;
        end else if (rf_wn) begin
            mem[rf_reg_id] <= rf_write_data;
        end
        if (rf_rd) rf_read_data <= mem[rf_reg_id];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 8; n++) begin
            if (!busy) break;
            step();
        end
        check(tag, 32'(busy), 0);
        step();
    endtask

    task automatic set_req(input int i, input logic wr, input logic [3:0] id, input logic [15:0] wd);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_reg_id[i*4 +: 4]  = id;
        req_wdata[i*16 +: 16] = wd;
    endtask

    function automatic int rr_pick(input logic [NUM-1:0] v, input logic [NUM-1:0] w, input int ptr);
        logic [NUM-1:0] cand;
        cand = v;
`ifdef RF_ARB_WRITE_FIRST_EN
        if ((v & w) != 0) cand = v & w;
`endif
        for (int k = 0; k < NUM; k++) begin
            if (cand[(ptr + k) % NUM]) return (ptr + k) % NUM;
        end
        return -1;
    endfunction

    initial begin
        int w;
        int exp_first;
        int exp_second;
        logic [NUM-1:0] got;
        logic [NUM-1:0] pre_v;
        logic [NUM-1:0] pre_w;
        int m_ptr;
        int win;
        int grants;
        int rd_granted;
        int rd_answered;
        int err_excl;
        int err_onehot;
        int err_winner;
        int err_rsp;
        logic        pend;
        int          pend_owner;
        logic [15:0] pend_data;

        reset      = 1'b0;
        mdl_init   = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_reg_id = '0;
        req_wdata  = '0;
        step();
        step();
        check("reset_ctrl", {29'd0, rf_rd, rf_wn, busy}, 0);
        check("reset_ready_rsp", {26'd0, req_ready, rsp_valid}, 0);
        check("reset_data", {rf_reg_id, rf_write_data}, 0);
        mdl_init = 1'b0;
        reset    = 1'b1;
        step();

        // 1: single write from req0
        set_req(0, 1'b1, 4'd5, 16'hBEEF);
        step();
        check("t1_ready", 32'(req_ready), 32'b001);
        check("t1_wn_rd", {30'd0, rf_wn, rf_rd}, 32'b10);
        check("t1_reg_id", 32'(rf_reg_id), 5);
        check("t1_wdata", 32'(rf_write_data), 32'hBEEF);
        check("t1_busy", 32'(busy), 1);
        req_valid = '0;
        step();
        check("t1_done", {28'd0, req_ready, busy}, 0);
        check("t1_wn_low", 32'(rf_wn), 0);

        // 2: req1 reads back reg 5
        set_req(1, 1'b0, 4'd5, 16'h0000);
        step();
        check("t2_ready", 32'(req_ready), 32'b010);
        check("t2_rd", {30'd0, rf_rd, rf_wn}, 32'b10);
        req_valid = '0;
        step();
        check("t2_capture", {28'd0, rsp_valid, busy}, 1);
        step();
        check("t2_rsp_valid", 32'(rsp_valid), 32'b010);
        check("t2_rsp_data", 32'(rsp_data), 32'hBEEF);
        check("t2_busy", 32'(busy), 0);
        step();
        check("t2_rsp_pulse", 32'(rsp_valid), 0);

        // 3: continuous reads from everyone; rr_ptr is 2 after test 2
        for (int i = 0; i < NUM; i++) set_req(i, 1'b0, 4'(i + 1), 16'h0);
        for (int g = 0; g < 6; g++) begin
            w = (2 + g) % NUM;
            step();
            check("t3_grant", 32'(req_ready), 32'(1) << w);
            step();
            check("t3_gap", 32'(req_ready), 0);
            step();
            check("t3_rsp_valid", 32'(rsp_valid), 32'(1) << w);
            check("t3_rsp_data", 32'(rsp_data), 32'(16'h1111 * (w + 1)));
        end
        req_valid = '0;

        // 4: bring rr_ptr to 0 with a req2 write, then read/write race
        set_req(2, 1'b1, 4'd7, 16'h1234);
        step();
        check("t4_pre_ready", 32'(req_ready), 32'b100);
        req_valid = '0;
        step();
        set_req(0, 1'b0, 4'd7, 16'h0);
        set_req(2, 1'b1, 4'd8, 16'h5A5A);
`ifdef RF_ARB_WRITE_FIRST_EN
        exp_first  = 2;
        exp_second = 0;
`else
        exp_first  = 0;
        exp_second = 2;
`endif
        step();
        check("t4_first", 32'(req_ready), 32'(1) << exp_first);
        req_valid[exp_first] = 1'b0;
        got = '0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (req_ready != 0) begin
                got = req_ready;
                break;
            end
        end
        check("t4_second", 32'(got), 32'(1) << exp_second);
        req_valid = '0;
        wait_idle("t4_idle");
        check("t4_mem8", 32'(mem[8]), 32'h5A5A);

        // 5: reset during CAPTURE of a read
        set_req(0, 1'b0, 4'd5, 16'hCAFE);
        step();
        check("t5_ready", 32'(req_ready), 32'b001);
        req_valid = '0;
        step();
        check("t5_in_capture", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t5_async_ctrl", {26'd0, req_ready, rsp_valid, rf_rd, rf_wn, busy} , 0);
        check("t5_async_data", {rf_reg_id, rf_write_data}, 0);
        check("t5_async_rsp", 32'(rsp_data), 0);
        step();
        step();
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            check("t5_no_rsp", 32'(rsp_valid), 0);
        end
        set_req(0, 1'b0, 4'd1, 16'h0);
        set_req(1, 1'b0, 4'd2, 16'h0);
        step();
        check("t5_ptr_reset", 32'(req_ready), 32'b001);
        req_valid = '0;
        wait_idle("t5_idle");

        // 6: random traffic against a reference arbiter model
        m_ptr       = 1;
        grants      = 0;
        rd_granted  = 0;
        rd_answered = 0;
        err_excl    = 0;
        err_onehot  = 0;
        err_winner  = 0;
        err_rsp     = 0;
        pend        = 1'b0;
        pend_owner  = 0;
        pend_data   = '0;
        for (int c = 0; c < 10000; c++) begin
            pre_v = req_valid;
            pre_w = req_write;
            step();
            if (rf_rd && rf_wn) err_excl++;
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) err_onehot++;
            if (rsp_valid != 0) begin
                rd_answered++;
                if (!pend || rsp_valid != (NUM'(1) << pend_owner) || rsp_data != pend_data) err_rsp++;
                pend = 1'b0;
            end
            if (req_ready != 0) begin
                grants++;
                win = rr_pick(pre_v, pre_w, m_ptr);
                if (win < 0 || req_ready != (NUM'(1) << win)) begin
                    err_winner++;
                end else begin
                    m_ptr = (win + 1) % NUM;
                    if (!pre_w[win]) begin
                        rd_granted++;
                        if (pend) err_rsp++;
                        pend       = 1'b1;
                        pend_owner = win;
                        pend_data  = mem[req_reg_id[win*4 +: 4]];
                    end
                end
            end
            for (int i = 0; i < NUM; i++) begin
                if (req_ready[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            16'($urandom_range(0, 65535)));
                end
            end
        end
        req_valid = '0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (rsp_valid != 0) begin
                rd_answered++;
                if (!pend || rsp_valid != (NUM'(1) << pend_owner) || rsp_data != pend_data) err_rsp++;
                pend = 1'b0;
            end
        end
        check("rand_exclusive", 32'(err_excl), 0);
        check("rand_onehot", 32'(err_onehot), 0);
        check("rand_winner", 32'(err_winner), 0);
        check("rand_rsp", 32'(err_rsp), 0);
        check("rand_answered", 32'(rd_answered), 32'(rd_granted));
        check("rand_activity", 32'(grants > 1000), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
